itof_pipe: RTL and testbench

//  Pipelined integer-to-FP32 converter for the VLIW FPU lane. Supports signed or unsigned input per transaction.

---
 rtl/fpu_pkg.sv | 11 +
 rtl/itof_lzc.sv | 29 ++
 rtl/itof_pipe.sv | 106 ++++++++++
 tb/tb_itof_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: FP32 format constants and packed field view shared by the FPU lane
package fpu_pkg;
  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_EXP_W = 8;
  typedef struct packed {
    logic sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;
endpackage

// File: rtl/itof_lzc.sv
// itof_lzc: combinational binary-tree leading-one locator
// Ports: i_data (W) operand; o_idx index of the highest set bit; o_zero high when i_data is all zeros.
module itof_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]         i_data,
  output logic [$clog2(W)-1:0] o_idx,
  output logic                 o_zero
);
  localparam int KW = $clog2(W);
  localparam int P = 1 << KW;
  logic [P-1:0]  w_v  [KW+1];
  logic [KW-1:0] w_ix [KW+1][P];
  // Level l merges pairs from level l-1; a valid upper child wins and contributes index bit l-1.
  always_comb begin
    for (int l = 0; l <= KW; l++) begin
      w_v[l] = '0;
      for (int n = 0; n < P; n++) w_ix[l][n] = '0;
    end
    w_v[0][W-1:0] = i_data;
    for (int l = 1; l <= KW; l++)
      for (int n = 0; n < (P >> l); n++) begin
        w_v[l][n] = w_v[l-1][2*n] | w_v[l-1][2*n+1];
        w_ix[l][n] = w_v[l-1][2*n+1] ? (w_ix[l-1][2*n+1] | (KW'(1) << (l-1))) : w_ix[l-1][2*n];
      end
  end
  assign o_idx = w_ix[KW][0];
  assign o_zero = !w_v[KW][0];
endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage integer to FP32 converter, round-to-nearest-even, valid/ready both sides
// Ports: in_valid/in_ready/in_data/in_uns/in_tag operand side; out_valid/out_ready/out_data/out_tag result side.
// Macro ITOF_PIPE_FLAGS_EN adds out_inexact (guard|sticky of the result, aligned with out_data).
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_uns,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef ITOF_PIPE_FLAGS_EN
  , output logic           out_inexact
`endif
);
  localparam int KW = $clog2(IN_W);
  localparam int FW = IN_W - 1 + FP32_MAN_W + 1;
  logic              r_v1, r_v2;
  logic [TAG_W-1:0]  r_tag1, r_tag2;
  logic              r_sign1, r_sign2;
  logic [IN_W-1:0]   r_mag1;
  logic [IN_W-2:0]   r_norm2;
  logic [KW-1:0]     r_k2;
  logic              r_zero2;
  logic              w_ld1, w_ld2, w_ld3;
  logic              w_sign0;
  logic [IN_W-1:0]   w_mag0;
  logic [KW-1:0]     w_k1;
  logic              w_zero1;
  logic [IN_W-2:0]   w_norm1;
  logic [FW-1:0]     w_f;
  logic [FP32_MAN_W-1:0] w_man, w_man_r;
  logic              w_g, w_s, w_up, w_cy;
  fp32_t             w_res;
  assign w_ld3 = !out_valid | out_ready;
  assign w_ld2 = !r_v2 | w_ld3;
  assign w_ld1 = !r_v1 | w_ld2;
  assign in_ready = w_ld1;
  assign w_sign0 = !in_uns & in_data[IN_W-1];
  assign w_mag0 = w_sign0 ? -in_data : in_data;
  itof_lzc #(.W(IN_W)) u_lzc (
    .i_data (r_mag1),
    .o_idx  (w_k1),
    .o_zero (w_zero1)
  );
  // The leading one lands on the dropped MSB, so only the fraction bits are kept.
  assign w_norm1 = (IN_W-1)'(r_mag1 << (KW'(IN_W-1) - w_k1));
  // Zero-pad below the fraction so guard/sticky exist even for narrow inputs (they fold to 0).
  assign w_f = {r_norm2, {(FP32_MAN_W+1){1'b0}}};
  assign w_man = w_f[FW-1 -: FP32_MAN_W];
  assign w_g = w_f[FW-1-FP32_MAN_W];
  assign w_s = |w_f[FW-2-FP32_MAN_W:0];
  assign w_up = w_g & (w_s | w_man[0]);
  assign {w_cy, w_man_r} = {1'b0, w_man} + (FP32_MAN_W+1)'(w_up);
  assign w_res = r_zero2 ? '0 : fp32_t'{
    sign: r_sign2,
    exp:  FP32_EXP_W'(FP32_EXP_BIAS) + FP32_EXP_W'(r_k2) + FP32_EXP_W'(w_cy),
    man:  w_man_r
  };
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
`ifdef ITOF_PIPE_FLAGS_EN
      out_inexact <= 1'b0;
`endif
    end else begin
      if (w_ld1) r_v1 <= in_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) out_valid <= r_v2;
      if (w_ld3 & r_v2) begin
        out_data <= w_res;
        out_tag <= r_tag2;
`ifdef ITOF_PIPE_FLAGS_EN
        out_inexact <= w_g | w_s;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_ld1 & in_valid) begin
      r_tag1 <= in_tag;
      r_sign1 <= w_sign0;
      r_mag1 <= w_mag0;
    end
    if (w_ld2 & r_v1) begin
      r_tag2 <= r_tag1;
      r_sign2 <= r_sign1;
      r_norm2 <= w_norm1;
      r_k2 <= w_k1;
      r_zero2 <= w_zero1;
    end
  end
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: scoreboard bench for itof_pipe (IN_W=32, TAG_W=5)
module tb_itof_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, in_uns = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [31:0] in_data = 0, out_data;
  logic [4:0]  in_tag = 0, out_tag;
`ifdef ITOF_PIPE_FLAGS_EN
  logic        out_inexact;
`endif
  typedef struct {logic [31:0] f; logic [4:0] t; logic i;} exp_t;
  exp_t        sb[$];
  int          n_tot = 0, n_bad = 0;
  logic        hold = 0, done = 0;
  logic [31:0] hd, d;
  logic [4:0]  ht, t;
  logic        u;
  always #5 clk = ~clk;
  itof_pipe #(.IN_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_uns(in_uns), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef ITOF_PIPE_FLAGS_EN
    , .out_inexact(out_inexact)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Reference through the simulator's exact double conversion, then RNE to single.
  function automatic exp_t model(input logic [31:0] dv, input logic uv, input logic [4:0] tv);
    real r;
    logic [63:0] b;
    logic [22:0] m;
    logic [23:0] mr;
    logic g, s;
    exp_t x;
    x.t = tv; x.f = 0; x.i = 0;
    r = uv ? real'({32'b0, dv}) : real'($signed(dv));
    if (dv != 0) begin
      b = $realtobits(r);
      m = b[51:29]; g = b[28]; s = |b[27:0];
      mr = {1'b0, m} + 24'(g & (s | m[0]));
      x.f = {b[63], 8'(b[62:52] - 11'd896) + 8'(mr[23]), mr[22:0]};
      x.i = g | s;
    end
    return x;
  endfunction
  task automatic send(input logic [31:0] dv, input logic uv, input logic [4:0] tv, input exp_t x);
    int n;
    logic acc;
    n = 0; acc = 0;
    in_valid = 1; in_data = dv; in_uns = uv; in_tag = tv;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 0;
    if (acc) sb.push_back(x);
    else chk("send_timeout", 0, 1);
  endtask
  task automatic dir(input logic [31:0] dv, input logic uv, input logic [4:0] tv, input logic [31:0] f, input logic i);
    send(dv, uv, tv, '{f, tv, i});
  endtask
  task automatic drain();
    int n;
    n = 0;
    out_ready = 1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst) hold <= 0;
    else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hd);
        chk("hold_tag", out_tag, ht);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("data", out_data, sb[0].f);
          chk("tag", out_tag, sb[0].t);
`ifdef ITOF_PIPE_FLAGS_EN
          chk("inexact", out_inexact, sb[0].i);
`endif
          void'(sb.pop_front());
        end
      end
      hold <= out_valid && !out_ready;
      hd <= out_data;
      ht <= out_tag;
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end
  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1;
    dir(32'd1, 0, 1, 32'h3F800000, 0);
    dir(32'hFFFFFFFF, 0, 2, 32'hBF800000, 0);
    dir(32'd0, 0, 3, 32'h00000000, 0);
    dir(32'd0, 1, 4, 32'h00000000, 0);
    dir(32'h80000000, 0, 5, 32'hCF000000, 0);
    dir(32'h80000000, 1, 6, 32'h4F000000, 0);
    dir(32'hFFFFFFFF, 1, 7, 32'h4F800000, 1);
    dir(32'd16777217, 0, 8, 32'h4B800000, 1);
    dir(32'd16777219, 0, 9, 32'h4B800002, 1);
    dir(32'd16777221, 1, 10, 32'h4B800002, 1);
    dir(32'd16777216, 0, 11, 32'h4B800000, 0);
    dir(32'd2, 1, 12, 32'h40000000, 0);
    drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(32'(i * 1000 - 1500), 0, 5'(i), model(32'(i * 1000 - 1500), 0, 5'(i)));
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    fork
      for (int i = 3; i < 8; i++) send(32'(i * 1000 - 1500), 0, 5'(i), model(32'(i * 1000 - 1500), 0, 5'(i)));
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    send(32'd100, 0, 20, model(32'd100, 0, 20));
    send(32'd200, 0, 21, model(32'd200, 0, 21));
    rst = 1;
    sb.delete();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    repeat (5) @(posedge clk);
    #1;
    send(32'd300, 0, 22, model(32'd300, 0, 22));
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 10);
    chk("latency", c, 3);
    @(posedge clk);
    #1;
    drain();
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          d = $urandom;
          case ($urandom_range(0, 3))
            0: d = d >> $urandom_range(0, 31);
            1: d = 32'h01000000 + $urandom_range(0, 15);
            default: ;
          endcase
          u = 1'($urandom_range(0, 1));
          t = 5'($urandom);
          send(d, u, t, model(d, u, t));
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
